gpu_cmd_sequencer: RTL

Front-end controller for the text-mode glyph buffers. It synchronises the host's asynchronous command strobe, decodes the 2-bit command, and owns the text cursor. It drives the single write port of the inactive glyph buffer and sequences multi-cycle operations: a full-buffer clear, and a buffer swap deferred to vertical blanking. It sits between the CPU bus interface and the glyph buffer RAM / pixel pipeline of the GPU.

---
 rtl/gpu_cmd_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_sequencer.sv
// rtl/gpu_cmd_sequencer.sv - text-mode command front end: strobe sync, cursor, clear and vblank swap
module gpu_cmd_sequencer #(
  parameter int         TEXT_W      = 80,
  parameter int         TEXT_H      = 60,
  parameter int         ADDR_W      = 13,
  parameter logic [7:0] CLEAR_GLYPH = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              interrupt_enable,
  input  logic [1:0]        interrupt_in,
  input  logic [7:0]        data_in,
  input  logic              vblank,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]        buf_wr_data,
  output logic              buf_wr_sel,
  output logic              active_buf,
  output logic [6:0]        cursor_x,
  output logic [5:0]        cursor_y,
  output logic              busy,
  output logic              overrun
);

  localparam logic [1:0] CMD_STORE   = 2'b00;
  localparam logic [1:0] CMD_MOVE    = 2'b01;
  localparam logic [1:0] CMD_DISPLAY = 2'b10;
  localparam logic [1:0] CMD_CLEAR   = 2'b11;

  localparam logic [ADDR_W-1:0] CELLS      = ADDR_W'(TEXT_W * TEXT_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(TEXT_W);
  localparam logic [6:0]        X_LAST     = 7'(TEXT_W - 1);
  localparam logic [5:0]        Y_LAST     = 6'(TEXT_H - 1);
  localparam logic [7:0]        X_MOD      = 8'(TEXT_W);
  localparam logic [6:0]        Y_MOD      = 7'(TEXT_H);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SWAP_WAIT} state_t;

  state_t            state;
  logic              strobe_meta;
  logic              strobe_sync;
  logic              strobe_prev;
  logic              cmd_det;
  logic              pend_valid;
  logic [1:0]        pend_cmd;
  logic [7:0]        pend_data;
  // Runs one ahead of the address on the bus: the first clear write is
  // issued together with the transition into S_CLEAR.
  logic [ADDR_W-1:0] clr_cnt;

  logic              exec_valid;
  logic [1:0]        exec_cmd;
  logic [7:0]        exec_data;
  logic [ADDR_W-1:0] cursor_addr;
  logic [7:0]        x_sum;
  logic [7:0]        x_red;
  logic [6:0]        x_mod;
  logic [6:0]        y_sum;
  logic [6:0]        y_red;
  logic [5:0]        y_mod;

  assign cmd_det    = strobe_sync & ~strobe_prev;
  assign buf_wr_sel = ~active_buf;

  // Pick the command to run this cycle in IDLE: a pending one always goes first
  always_comb begin
    exec_valid = 1'b0;
    exec_cmd   = interrupt_in;
    exec_data  = data_in;
    if (state == S_IDLE) begin
      if (pend_valid) begin
        exec_valid = 1'b1;
        exec_cmd   = pend_cmd;
        exec_data  = pend_data;
      end else if (cmd_det) begin
        exec_valid = 1'b1;
      end
    end
  end

  // Cursor address and modular cursor moves (sums stay below 3*modulus)
  always_comb begin
    cursor_addr = ADDR_W'(cursor_y) * ROW_STRIDE + ADDR_W'(cursor_x);
    x_sum = {1'b0, cursor_x} + {1'b0, exec_data[6:0]};
    x_red = (x_sum >= X_MOD) ? x_sum - X_MOD : x_sum;
    x_mod = (x_red >= X_MOD) ? 7'(x_red - X_MOD) : x_red[6:0];
    y_sum = {1'b0, cursor_y} + {1'b0, exec_data[5:0]};
    y_red = (y_sum >= Y_MOD) ? y_sum - Y_MOD : y_sum;
    y_mod = (y_red >= Y_MOD) ? 6'(y_red - Y_MOD) : y_red[5:0];
  end

  // Strobe synchroniser, pending slot and the command FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      strobe_meta <= 1'b0;
      strobe_sync <= 1'b0;
      strobe_prev <= 1'b0;
      pend_valid  <= 1'b0;
      pend_cmd    <= 2'b00;
      pend_data   <= 8'h00;
      clr_cnt     <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= 8'h00;
      active_buf  <= 1'b0;
      cursor_x    <= 7'd0;
      cursor_y    <= 6'd0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      strobe_meta <= interrupt_enable;
      strobe_sync <= strobe_meta;
      strobe_prev <= strobe_sync;
      overrun     <= 1'b0;

      // Slot bookkeeping: in IDLE the slot drains as it executes and can be
      // refilled by a same-cycle arrival; while busy only an empty slot fills.
      if (state == S_IDLE) begin
        if (pend_valid) begin
          pend_valid <= cmd_det;
          if (cmd_det) begin
            pend_cmd  <= interrupt_in;
            pend_data <= data_in;
          end
        end
      end else if (cmd_det) begin
        if (!pend_valid) begin
          pend_valid <= 1'b1;
          pend_cmd   <= interrupt_in;
          pend_data  <= data_in;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          buf_wr_en <= 1'b0;
          if (exec_valid) begin
            case (exec_cmd)
              CMD_STORE: begin
                buf_wr_en   <= 1'b1;
                buf_wr_addr <= cursor_addr;
                buf_wr_data <= exec_data;
                if (cursor_x == X_LAST) begin
                  cursor_x <= 7'd0;
                  cursor_y <= (cursor_y == Y_LAST) ? 6'd0 : cursor_y + 6'd1;
                end else begin
                  cursor_x <= cursor_x + 7'd1;
                end
              end
              CMD_MOVE: begin
                if (exec_data[7]) cursor_x <= x_mod;
                else              cursor_y <= y_mod;
              end
              CMD_DISPLAY: begin
                state <= S_SWAP_WAIT;
                busy  <= 1'b1;
              end
              CMD_CLEAR: begin
                cursor_x    <= 7'd0;
                cursor_y    <= 6'd0;
                buf_wr_en   <= 1'b1;
                buf_wr_addr <= '0;
                buf_wr_data <= CLEAR_GLYPH;
                clr_cnt     <= ADDR_W'(1);
                state       <= S_CLEAR;
                busy        <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        S_CLEAR: begin
          if (clr_cnt == CELLS) begin
            buf_wr_en <= 1'b0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            buf_wr_en   <= 1'b1;
            buf_wr_addr <= clr_cnt;
            buf_wr_data <= CLEAR_GLYPH;
            clr_cnt     <= clr_cnt + ADDR_W'(1);
          end
        end

        S_SWAP_WAIT: begin
          buf_wr_en <= 1'b0;
          if (vblank) begin
            active_buf <= ~active_buf;
            state      <= S_IDLE;
            busy       <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
